// File: rtl/deskew_ctrl_rx.sv
// Receive-side deskew sequencer: collects per-lane alignment markers, checks the
// round spread against the buffer depth and drives the common lock-full/lock-lost controls.
module deskew_ctrl_rx #(
    parameter int LANE_N           = 4,
    parameter int MAX_SKEW_BLOCK_N = 27,
    parameter int WIN_CNT_W        = $clog2(MAX_SKEW_BLOCK_N) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [LANE_N-1:0] am_v_i,
    input  logic [LANE_N-1:0] am_lock_i,
    input  logic [LANE_N-1:0] skew_zero_i,
    output logic              am_lite_lock_full_v_o,
    output logic              am_lite_lock_lost_v_o,
    output logic              deskew_v_o,
    output logic              skew_err_o,
    output logic [LANE_N-1:0] seen_o
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ALIGNED
    } state_t;

    localparam logic [WIN_CNT_W-1:0] WIN_LIMIT = WIN_CNT_W'(MAX_SKEW_BLOCK_N - 1);

    state_t                state_q, state_d;
    logic [LANE_N-1:0]     seen_q, seen_d;
    logic [LANE_N-1:0]     chk_q, chk_d;
    logic [WIN_CNT_W-1:0]  win_q, win_d;
    logic [WIN_CNT_W-1:0]  chk_win_q, chk_win_d;
    logic                  first_q, first_d;
    logic                  full_d, lost_d, err_d;

    logic                  lock_all, any_v, all_v;
    logic [LANE_N-1:0]     seen_or, chk_or;
    logic [WIN_CNT_W-1:0]  win_inc_v, chk_win_inc_v;
    logic                  seen_rep, seen_done, seen_over;
    logic                  chk_rep, chk_done, chk_over;

    function automatic logic [WIN_CNT_W-1:0] win_inc(input logic [WIN_CNT_W-1:0] c);
        return (c == {WIN_CNT_W{1'b1}}) ? c : c + 1'b1;
    endfunction

    assign lock_all = &am_lock_i;
    assign any_v    = |am_v_i;
    assign all_v    = &am_v_i;

    // Initial-acquisition round
    assign seen_or   = seen_q | am_v_i;
    assign win_inc_v = win_inc(win_q);
    assign seen_rep  = |(am_v_i & seen_q);
    assign seen_done = &seen_or;
    assign seen_over = (win_inc_v >= WIN_LIMIT) && !seen_done;

    // Re-check rounds while aligned; idle when chk_q is empty
    assign chk_or        = chk_q | am_v_i;
    assign chk_win_inc_v = win_inc(chk_win_q);
    assign chk_rep       = |(am_v_i & chk_q);
    assign chk_done      = &chk_or;
    assign chk_over      = (chk_win_inc_v >= WIN_LIMIT) && !chk_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            seen_q    <= '0;
            chk_q     <= '0;
            win_q     <= '0;
            chk_win_q <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seen_q    <= seen_d;
            chk_q     <= chk_d;
            win_q     <= win_d;
            chk_win_q <= chk_win_d;
            first_q   <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        seen_d    = seen_q;
        chk_d     = chk_q;
        win_d     = win_q;
        chk_win_d = chk_win_q;
        first_d   = 1'b0;
        full_d    = 1'b0;
        lost_d    = 1'b0;
        err_d     = 1'b0;

        if (!lock_all) begin
            state_d = IDLE;
            seen_d  = '0;
            chk_d   = '0;
            lost_d  = (state_q == ALIGNED);
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_v) begin
                        seen_d = am_v_i;
                        win_d  = '0;
                        if (all_v) begin
                            state_d = ALIGNED;
                            first_d = 1'b1;
                            chk_d   = '0;
                            full_d  = 1'b1;
                        end else begin
                            state_d = COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    seen_d = seen_or;
                    win_d  = win_inc_v;
                    if (seen_rep || seen_over) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                        seen_d  = '0;
                    end else if (seen_done) begin
                        state_d = ALIGNED;
                        first_d = 1'b1;
                        chk_d   = '0;
                        full_d  = 1'b1;
                    end
                end
                ALIGNED: begin
                    full_d = 1'b1;
                    if (first_q && !(|skew_zero_i)) begin
                        err_d   = 1'b1;
                        full_d  = 1'b0;
                        state_d = IDLE;
                        seen_d  = '0;
                        chk_d   = '0;
                    end else if (|chk_q) begin
                        chk_d     = chk_or;
                        chk_win_d = chk_win_inc_v;
                        if (chk_rep || chk_over) begin
                            err_d   = 1'b1;
                            lost_d  = 1'b1;
                            full_d  = 1'b0;
                            state_d = IDLE;
                            seen_d  = '0;
                            chk_d   = '0;
                        end else if (chk_done) begin
                            chk_d = '0;
                        end
                    end else if (any_v) begin
                        chk_d     = all_v ? '0 : am_v_i;
                        chk_win_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    seen_d  = '0;
                    chk_d   = '0;
                end
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            am_lite_lock_full_v_o <= 1'b0;
            am_lite_lock_lost_v_o <= 1'b0;
            deskew_v_o            <= 1'b0;
            skew_err_o            <= 1'b0;
        end else begin
            am_lite_lock_full_v_o <= full_d;
            am_lite_lock_lost_v_o <= lost_d;
            deskew_v_o            <= full_d;
            skew_err_o            <= err_d;
        end
    end

    assign seen_o = seen_q;

endmodule

// File: tb/tb_deskew_ctrl_rx.sv
// Randomized bench for deskew_ctrl_rx against a cycle-count reference model of
// marker rounds (spread measured as cycle difference from the round's first marker).
module tb_deskew_ctrl_rx;

    localparam int MAX_SPREAD = 26;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] am_v, am_lock, skew_zero;
    logic       full, lost, deskew, err;
    logic [3:0] seen;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model state
    int         m_mode;  // 0 idle, 1 collecting, 2 aligned
    logic [3:0] m_seen, m_chk;
    int         m_first, m_chk_first;
    bit         m_new;
    logic       e_full, e_lost, e_err;
    logic [3:0] e_seen;

    deskew_ctrl_rx #(.LANE_N(4), .MAX_SKEW_BLOCK_N(27)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .am_v_i                (am_v),
        .am_lock_i             (am_lock),
        .skew_zero_i           (skew_zero),
        .am_lite_lock_full_v_o (full),
        .am_lite_lock_lost_v_o (lost),
        .deskew_v_o            (deskew),
        .skew_err_o            (err),
        .seen_o                (seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_seen = '0; m_chk = '0; m_first = 0; m_chk_first = 0; m_new = 0;
        e_full = 0; e_lost = 0; e_err = 0; e_seen = '0;
    endtask

    task automatic model_step();
        logic [3:0] acc;
        e_lost = 0;
        e_err  = 0;
        if (am_lock != 4'hF) begin
            if (m_mode == 2) e_lost = 1;
            m_mode = 0; m_seen = '0; m_chk = '0; m_new = 0;
        end else if (m_mode == 0) begin
            if (am_v != 4'h0) begin
                m_seen  = am_v;
                m_first = cyc;
                if (am_v == 4'hF) begin
                    m_mode = 2; m_new = 1; m_chk = '0;
                end else begin
                    m_mode = 1;
                end
            end
        end else if (m_mode == 1) begin
            acc = m_seen | am_v;
            if ((am_v & m_seen) != 4'h0 || (cyc - m_first >= MAX_SPREAD && acc != 4'hF)) begin
                e_err = 1; m_mode = 0; m_seen = '0;
            end else begin
                m_seen = acc;
                if (acc == 4'hF) begin
                    m_mode = 2; m_new = 1; m_chk = '0;
                end
            end
        end else begin
            if (m_new && skew_zero == 4'h0) begin
                e_err = 1; m_mode = 0; m_seen = '0; m_chk = '0;
            end else if (m_chk != 4'h0) begin
                acc = m_chk | am_v;
                if ((am_v & m_chk) != 4'h0 || (cyc - m_chk_first >= MAX_SPREAD && acc != 4'hF)) begin
                    e_err = 1; e_lost = 1; m_mode = 0; m_seen = '0; m_chk = '0;
                end else begin
                    m_chk = (acc == 4'hF) ? 4'h0 : acc;
                end
            end else if (am_v != 4'h0) begin
                m_chk       = (am_v == 4'hF) ? 4'h0 : am_v;
                m_chk_first = cyc;
            end
            m_new = 0;
        end
        e_full = (m_mode == 2);
        e_seen = m_seen;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("full",   32'(full),   32'(e_full));
        check("deskew", 32'(deskew), 32'(e_full));
        check("lost",   32'(lost),   32'(e_lost));
        check("err",    32'(err),    32'(e_err));
        check("seen",   32'(seen),   32'(e_seen));
    endtask

    task automatic idle(input int n);
        am_v = 4'h0;
        repeat (n) tick();
    endtask

    // Offsets are cycles after the round start; a negative offset leaves the lane silent
    task automatic send_round(input int o0, input int o1, input int o2, input int o3);
        int mx;
        mx = o0;
        if (o1 > mx) mx = o1;
        if (o2 > mx) mx = o2;
        if (o3 > mx) mx = o3;
        for (int c = 0; c <= mx; c++) begin
            am_v = {o3 == c, o2 == c, o1 == c, o0 == c};
            tick();
        end
        am_v = 4'h0;
    endtask

    task automatic drop_lock(input logic [3:0] l);
        am_lock = l;
        tick();
        am_lock = 4'hF;
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b1;
        am_v  = 4'h0;
        #1;
        check("arst_full",   32'(full),   32'd0);
        check("arst_deskew", 32'(deskew), 32'd0);
        check("arst_lost",   32'(lost),   32'd0);
        check("arst_err",    32'(err),    32'd0);
        check("arst_seen",   32'(seen),   32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    int r0, r1, r2, r3, rmax;

    initial begin
        reset     = 1'b1;
        am_v      = 4'h0;
        am_lock   = 4'h0;
        skew_zero = 4'hF;
        model_reset();
        #12;
        check("rst_full",   32'(full),   32'd0);
        check("rst_deskew", 32'(deskew), 32'd0);
        check("rst_lost",   32'(lost),   32'd0);
        check("rst_err",    32'(err),    32'd0);
        check("rst_seen",   32'(seen),   32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // All lanes aligned
        am_lock = 4'hF;
        idle(5);
        send_round(0, 0, 0, 0);
        check("aligned_full", 32'(full), 32'd1);
        idle(3);
        check("aligned_noerr", 32'(err), 32'd0);

        // Lock loss while aligned
        drop_lock(4'b1011);
        check("lockdrop_lost", 32'(lost), 32'd1);
        check("lockdrop_full", 32'(full), 32'd0);
        check("lockdrop_err",  32'(err),  32'd0);
        idle(2);

        // Staggered arrival
        skew_zero = 4'h8;
        send_round(0, 2, 5, 10);
        check("stagger_full", 32'(full), 32'd1);
        idle(3);
        skew_zero = 4'hF;

        // Skew boundary
        drop_lock(4'h0);
        send_round(0, 5, 13, 26);
        check("bound26_full", 32'(full), 32'd1);
        idle(2);
        drop_lock(4'h0);
        send_round(0, 5, 13, 27);
        idle(30);

        // Repeated marker before the round completes
        am_v = 4'h1; tick();
        am_v = 4'h6; tick();
        idle(2);
        am_v = 4'h1; tick();
        check("repeat_err", 32'(err), 32'd1);
        idle(3);
        send_round(0, 1, 2, 3);
        check("after_repeat_full", 32'(full), 32'd1);

        // Inconsistent skew pointers on entry to ALIGNED
        drop_lock(4'h0);
        skew_zero = 4'h0;
        send_round(0, 0, 0, 0);
        idle(2);
        skew_zero = 4'hF;

        // Re-check rounds while aligned, then a failing one
        send_round(0, 1, 2, 3);
        idle(2);
        send_round(3, 0, 1, 2);
        idle(2);
        send_round(0, 0, 20, 28);
        idle(3);

        // Asynchronous reset in the middle of a round
        am_v = 4'h1; tick();
        do_reset();
        idle(2);
        send_round(0, 0, 1, 1);
        check("post_reset_full", 32'(full), 32'd1);

        // Randomized rounds with occasional lock drops and bad skew pointers
        for (int r = 0; r < 40; r++) begin
            rmax = ($urandom_range(0, 3) == 0) ? 30 : 20;
            r0 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, rmax));
            r1 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, rmax));
            r2 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, rmax));
            r3 = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, rmax));
            skew_zero = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) drop_lock(4'($urandom_range(0, 14)));
            send_round(r0, r1, r2, r3);
            idle($urandom_range(0, 6));
        end
        idle(30);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/deskew_ctrl_rx.md
# deskew_ctrl_rx

Receive-side multi-lane deskew controller. Sits beside the per-lane deskew buffers and sequences them. It watches per-lane alignment-marker arrivals and lane lock, measures inter-lane skew against the buffer depth, and asserts the common lock-full signal that freezes every lane's skew pointer. It also signals lock loss so the lanes re-acquire, and flags skew that exceeds buffer capacity.

## Interface
- `LANE_N`, 4: number of PCS lanes.
- `MAX_SKEW_BLOCK_N`, 27: per-lane buffer depth in blocks; the maximum tolerated skew is `MAX_SKEW_BLOCK_N-1` blocks.
- `WIN_CNT_W`, `$clog2(MAX_SKEW_BLOCK_N)+1`: width of the skew window counter.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `am_v_i` in `LANE_N`: per-lane alignment marker block valid this cycle (pre-deskew).
- `am_lock_i` in `LANE_N`: per-lane alignment marker lock.
- `skew_zero_i` in `LANE_N`: per-lane "skew pointer is zero" indicator from the lane buffers.
- `am_lite_lock_full_v_o` out 1: all lanes aligned; freezes the lane skew counters.
- `am_lite_lock_lost_v_o` out 1: one-cycle pulse on loss of deskew lock.
- `deskew_v_o` out 1: deskewed lane data is valid.
- `skew_err_o` out 1: one-cycle pulse when skew exceeds the window or a marker round is malformed.
- `seen_o` out `LANE_N`: markers collected in the current round (debug).

## Operation
- FSM states: IDLE, COLLECT, ALIGNED.
- **IDLE**
  - Entered on reset or any error.
  - Waits for `&am_lock_i`.
  - Once lanes are locked, the first cycle with `|am_v_i` loads `seen = am_v_i`, clears the window counter, and goes to COLLECT.
  - If `&am_v_i` holds in that same cycle, it goes directly to ALIGNED.
- **COLLECT**
  - Each cycle: `seen |= am_v_i`; the window counter increments.
  - When `seen` becomes all-ones, go to ALIGNED on the next edge.
  - Error, return to IDLE and pulse `skew_err_o`, if either:
    - the window counter reaches `MAX_SKEW_BLOCK_N-1` with `seen` incomplete, or
    - `am_v_i & seen` is non-zero (a lane repeated its marker before the round completed).
- **ALIGNED**
  - `am_lite_lock_full_v_o = 1` and `deskew_v_o = 1`.
  - First cycle in ALIGNED: if `~|skew_zero_i`, the state is inconsistent; pulse `skew_err_o` and go to IDLE.
  - Subsequent marker rounds are re-checked with the same window and repeat rules, using a separate seen mask and counter.
  - A failing round pulses `skew_err_o` and `am_lite_lock_lost_v_o`, then goes to IDLE.
- **Lock drop:** any de-assertion of `&am_lock_i` in any state goes to IDLE next edge.
  - It pulses `am_lite_lock_lost_v_o` only if the FSM was in ALIGNED.
  - It does not pulse `skew_err_o`.
- **Priority when events coincide:** lock drop > skew error > round completion.
- **Window counter:** saturating, `WIN_CNT_W` bits, never wraps.
- **Round completion and repeats:** a round completing in the same cycle another lane repeats counts as an error.

## Timing
- Reset values: FSM = IDLE; `seen_o = 0`; `am_lite_lock_full_v_o`, `am_lite_lock_lost_v_o`, `deskew_v_o`, `skew_err_o` = 0.
- All outputs are registered.
- `am_lite_lock_full_v_o` rises one cycle after the cycle in which the last lane's marker is sampled.
  - The latest lane's skew pointer therefore freezes at 0.
  - Earlier lanes freeze at their arrival lead in blocks.
- `skew_err_o` and `am_lite_lock_lost_v_o` assert the cycle after the detecting event, for exactly one cycle.
- `am_lite_lock_full_v_o` and `deskew_v_o` drop in that same cycle.
- The maximum accepted skew is `MAX_SKEW_BLOCK_N-1` cycles between the first and last marker of a round (inclusive of the boundary).
- Reset asserted mid-round clears everything immediately (asynchronous).
- No new round may start until the cycle after reset release.

## Test plan
- **All aligned:** `am_lock_i=4'hF`, `am_v_i=4'hF` at cycle 10 -> `am_lite_lock_full_v_o=1` at cycle 11; with `skew_zero_i=4'hF`, no error.
- **Staggered markers:** markers on lanes 0, 1, 2, 3 at cycles 10, 12, 15, 20 -> lock_full at 21; `skew_zero_i=4'h8` accepted; `seen_o` progresses 1, 3, 7, F.
- **Skew boundary:**
  - last marker exactly 26 cycles after the first -> lock achieved;
  - last marker 27 cycles after the first -> `skew_err_o` pulse at cycle first+27, FSM in IDLE.
- **Repeat marker:** lane 0 marker at cycles 10 and 14 with lane 3 still absent -> `skew_err_o` pulse at 15; a new round then completes normally.
- **Lock loss:**
  - while ALIGNED, drop `am_lock_i[2]` -> `am_lite_lock_lost_v_o` one-cycle pulse, lock_full and `deskew_v_o` low the next cycle, no `skew_err_o`;
  - re-lock and realign succeeds.
- **Async reset in COLLECT:** assert `reset` mid-edge -> all outputs 0 without waiting for a clock edge; after release, a fresh round aligns.
